fpu_seq: RTL and testbench

Multi-cycle, parametrised IEEE-754 binary floating-point unit performing FADD and FMUL on operands of configurable exponent/mantissa width. It supports gradual underflow (subnormal inputs and outputs), round-to-nearest-even, canonical NaN handling and exception flags. It sits beside the integer ALU and exchanges operands and results through valid/ready handshakes, one operation in flight at a time. Default parameters give IEEE half precision, bit-compatible with the existing half-precision datapath.

---
 rtl/fpu_seq.sv | 256 +++++++++++++++++++++++++
 tb/tb_fpu_seq.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_seq.sv
// fpu_seq: multi-cycle IEEE-754 FADD/FMUL, parametrised format
// IDLE -> EXEC -> NORM -> DONE, one operation in flight

`ifndef FPU_FADD
`define FPU_FADD 4'b0001
`endif
`ifndef FPU_FMUL
`define FPU_FMUL 4'b0010
`endif

module fpu_seq #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic [3:0]           aluctrl,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 zero,
  output logic [3:0]           flags
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int M   = MAN_W + 1;
  localparam int NW  = 2 * MAN_W + 4;
  localparam int LZW = $clog2(NW + 1);
  localparam int EW  = ((EXP_W > LZW) ? EXP_W : LZW) + 3;
  localparam int PW  = EW + MAN_W;

  typedef logic signed [EW-1:0] exp_t;
  localparam exp_t BIAS = exp_t'((1 << (EXP_W - 1)) - 1);
  localparam exp_t EMAX = exp_t'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, EXEC, NORM, DONE} state_t;
  state_t state, state_n;

  logic [W-1:0]  a_q, b_q, spr_q;
  logic [3:0]    op_q, spf_q;
  logic          s_q, sp_q;
  exp_t          e_q;
  logic [NW-1:0] m_q;

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  assign {sa, ea, fa} = a_q;
  assign {sb, eb, fb} = b_q;

  logic nan_a, nan_b, snan_a, snan_b;
  logic inf_a, inf_b, zro_a, zro_b;
  assign nan_a  = (&ea) & (|fa);
  assign nan_b  = (&eb) & (|fb);
  assign snan_a = nan_a & ~fa[MAN_W-1];
  assign snan_b = nan_b & ~fb[MAN_W-1];
  assign inf_a  = (&ea) & ~(|fa);
  assign inf_b  = (&eb) & ~(|fb);
  assign zro_a  = ~(|ea) & ~(|fa);
  assign zro_b  = ~(|eb) & ~(|fb);

  logic [M-1:0] ma, mb;
  exp_t         xa, xb;
  assign ma = {|ea, fa};
  assign mb = {|eb, fb};
  assign xa = (|ea) ? exp_t'(ea) : exp_t'(1);
  assign xb = (|eb) ? exp_t'(eb) : exp_t'(1);

  logic           swap, sx, sy, sub, y_st;
  exp_t           ex, ey, dif;
  logic [M-1:0]   mx, my;
  logic [NW-1:0]  x_al, y_al, y_j, sum, mul;
  logic [2*M-1:0] prod;

  // Align and add/subtract for FADD; full significand product for FMUL
  always_comb begin
    swap = {eb, fb} > {ea, fa};
    sx   = swap ? sb : sa;
    sy   = swap ? sa : sb;
    ex   = swap ? xb : xa;
    ey   = swap ? xa : xb;
    mx   = swap ? mb : ma;
    my   = swap ? ma : mb;
    dif  = ex - ey;
    x_al = {1'b0, mx, {(MAN_W+2){1'b0}}};
    y_al = {1'b0, my, {(MAN_W+2){1'b0}}};
    y_st = |(y_al & ~({NW{1'b1}} << dif));
    y_j  = (y_al >> dif) | NW'(y_st);
    sub  = sx ^ sy;
    sum  = sub ? x_al - y_j : x_al + y_j;
    prod = {{M{1'b0}}, ma} * {{M{1'b0}}, mb};
    mul  = {prod, 2'b00};
  end

  logic          is_add, is_mul, sp_n, s_n;
  logic [W-1:0]  spr_n;
  logic [3:0]    spf_n;
  exp_t          e_n;
  logic [NW-1:0] m_n;

  // Special-operand resolution and EXEC stage results
  always_comb begin
    is_add = aluctrl_ok(op_q, `FPU_FADD);
    is_mul = aluctrl_ok(op_q, `FPU_FMUL);
    sp_n   = 1'b1;
    spr_n  = '0;
    spf_n  = '0;
    if (!(is_add || is_mul)) begin
      spr_n = '0;
    end else if (nan_a || nan_b) begin
      spr_n = QNAN;
      spf_n = {snan_a | snan_b, 3'b000};
    end else if (is_add && inf_a && inf_b && (sa ^ sb)) begin
      spr_n = QNAN;
      spf_n = 4'b1000;
    end else if (is_mul && ((inf_a && zro_b) || (zro_a && inf_b))) begin
      spr_n = QNAN;
      spf_n = 4'b1000;
    end else if (inf_a || inf_b) begin
      spr_n = {is_mul ? sa ^ sb : (inf_a ? sa : sb),
               {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      sp_n = 1'b0;
    end
    if (is_add) begin
      s_n = (sub && sum == '0) ? 1'b0 : sx;
      e_n = ex;
      m_n = sum;
    end else begin
      s_n = sa ^ sb;
      e_n = xa + xb - BIAS;
      m_n = mul;
    end
  end

  function automatic logic aluctrl_ok(input logic [3:0] o,
                                      input logic [3:0] c);
    return o == c;
  endfunction

  logic [LZW-1:0] lz;
  exp_t           sh, en, sl, rs, base;
  logic           tiny, st0, g, st, up, inx, ovf;
  logic [NW-1:0]  mn;
  logic [M-1:0]   kept;
  logic [PW-1:0]  pk;
  logic [W-1:0]   res_n;
  logic [3:0]     flg_n;

  // Normalise/denormalise, round to nearest even, pack and flag
  always_comb begin
    lz = LZW'(NW);
    for (int i = 0; i < NW; i++)
      if (m_q[i]) lz = LZW'(NW - 1 - i);
    sh   = exp_t'(lz) - exp_t'(1);
    en   = e_q - sh;
    tiny = en < exp_t'(1);
    sl   = tiny ? e_q - exp_t'(1) : sh;
    rs   = -sl;
    st0  = 1'b0;
    if (!sl[EW-1]) begin
      mn = m_q << sl;
    end else begin
      mn  = m_q >> rs;
      st0 = |(m_q & ~({NW{1'b1}} << rs));
    end
    kept = mn[NW-2 -: M];
    g    = mn[NW-2-M];
    st   = st0 | (|mn[NW-3-M:0]);
    up   = g & (st | kept[0]);
    inx  = g | st;
    base = tiny ? exp_t'(1) : en;
    pk   = {base - exp_t'(1), {MAN_W{1'b0}}}
         + PW'(kept) + PW'(up);
    ovf  = $signed(pk[PW-1:MAN_W]) >= EMAX;
    res_n = {s_q, pk[W-2:0]};
    flg_n = {2'b00, tiny & inx, inx};
    if (sp_q) begin
      res_n = spr_q;
      flg_n = spf_q;
    end else if (m_q == '0) begin
      res_n = {s_q, {(W-1){1'b0}}};
      flg_n = '0;
    end else if (ovf) begin
      res_n = {s_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg_n = 4'b0101;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (in_valid && in_ready) state_n = EXEC;
      EXEC: state_n = NORM;
      NORM: state_n = DONE;
      DONE: if (out_valid && out_ready) state_n = IDLE;
    endcase
  end

  // State register and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      in_ready  <= state_n == IDLE;
      out_valid <= (state == DONE) && (state_n == DONE);
    end
  end

  // Operand capture, EXEC results and final result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      s_q    <= 1'b0;
      e_q    <= '0;
      m_q    <= '0;
      sp_q   <= 1'b0;
      spr_q  <= '0;
      spf_q  <= '0;
      result <= '0;
      flags  <= '0;
    end else begin
      if (state == IDLE && in_valid && in_ready) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= aluctrl;
      end
      if (state == EXEC) begin
        s_q   <= s_n;
        e_q   <= e_n;
        m_q   <= m_n;
        sp_q  <= sp_n;
        spr_q <= spr_n;
        spf_q <= spf_n;
      end
      if (state == NORM) begin
        result <= res_n;
        flags  <= flg_n;
      end
    end
  end

  assign zero = ~(|result[W-2:0]);

endmodule

// File: tb/tb_fpu_seq.sv
// tb_fpu_seq: scoreboard bench for half and single precision fpu_seq
// covers arithmetic, specials, handshake stalls and mid-op reset

`ifndef FPU_FADD
`define FPU_FADD 4'b0001
`endif
`ifndef FPU_FMUL
`define FPU_FMUL 4'b0010
`endif

module tb_fpu_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] av, bv;
  logic [3:0]  op;

  logic        h_iv, h_ir, h_ov, h_or, h_z;
  logic [15:0] h_res;
  logic [3:0]  h_flg;
  logic        s_iv, s_ir, s_ov, s_or, s_z;
  logic [31:0] s_res;
  logic [3:0]  s_flg;

  fpu_seq u_h (
    .clk(clk), .rst_n(rst_n),
    .in_valid(h_iv), .in_ready(h_ir),
    .a(av[15:0]), .b(bv[15:0]), .aluctrl(op),
    .out_valid(h_ov), .out_ready(h_or),
    .result(h_res), .zero(h_z), .flags(h_flg)
  );

  fpu_seq #(.EXP_W(8), .MAN_W(23)) u_s (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_iv), .in_ready(s_ir),
    .a(av), .b(bv), .aluctrl(op),
    .out_valid(s_ov), .out_ready(s_or),
    .result(s_res), .zero(s_z), .flags(s_flg)
  );

  typedef struct packed {
    logic [31:0] r;
    logic [3:0]  f;
    logic        z;
  } sb_t;

  sb_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic send(input bit sel, input logic [31:0] x,
                      input logic [31:0] y, input logic [3:0] o);
    int n;
    @(negedge clk);
    av = x;
    bv = y;
    op = o;
    if (sel) s_iv = 1'b1;
    else h_iv = 1'b1;
    n = 0;
    while (!(sel ? s_ir : h_ir) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout in_ready stuck 0, want 1");
    end
    @(posedge clk);
    #1;
    h_iv = 1'b0;
    s_iv = 1'b0;
  endtask

  task automatic collect(input bit sel, output logic [31:0] r,
                         output logic [3:0] f, output logic z,
                         output int lat);
    lat = 0;
    @(negedge clk);
    while (!(sel ? s_ov : h_ov) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) begin
      checks++;
      errors++;
      $display("FAIL result_timeout out_valid stuck 0, want 1");
    end
    r = sel ? s_res : {16'h0, h_res};
    f = sel ? s_flg : h_flg;
    z = sel ? s_z : h_z;
    if (sel) s_or = 1'b1;
    else h_or = 1'b1;
    @(posedge clk);
    #1;
    h_or = 1'b0;
    s_or = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (h_ir !== 1'b0 || s_ir !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_ready got %b%b want 00", h_ir, s_ir);
    end
    checks++;
    if (h_ov !== 1'b0 || s_ov !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_valid got %b%b want 00", h_ov, s_ov);
    end
    checks++;
    if (h_res !== 16'h0 || h_flg !== 4'h0) begin
      errors++;
      $display("FAIL rst_result got %h/%b want 0000/0000", h_res, h_flg);
    end
    checks++;
    if (h_z !== 1'b1 || s_z !== 1'b1) begin
      errors++;
      $display("FAIL rst_zero got %b%b want 11", h_z, s_z);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (h_ir !== 1'b1 || s_ir !== 1'b1) begin
      errors++;
      $display("FAIL rst_release_ready got %b%b want 11", h_ir, s_ir);
    end
  endtask

  task automatic test_fadd();
    logic [15:0] xa [6] = '{16'h3C00, 16'h3C00, 16'h3C00,
                            16'h3C00, 16'h4000, 16'h0001};
    logic [15:0] xb [6] = '{16'h3C00, 16'h1000, 16'hBC00,
                            16'h1001, 16'hBC00, 16'h0001};
    logic [15:0] er [6] = '{16'h4000, 16'h3C00, 16'h0000,
                            16'h3C01, 16'h3C00, 16'h0002};
    logic [3:0]  ef [6] = '{4'b0000, 4'b0001, 4'b0000,
                            4'b0001, 4'b0000, 4'b0000};
    logic [31:0] r;
    logic [3:0]  f;
    logic        z;
    int          lat;
    sb_t         e;
    for (int i = 0; i < 6; i++) begin
      sb_q.push_back('{r: {16'h0, er[i]}, f: ef[i],
                       z: er[i][14:0] == 15'h0});
      send(1'b0, {16'h0, xa[i]}, {16'h0, xb[i]}, `FPU_FADD);
      collect(1'b0, r, f, z, lat);
      e = sb_q.pop_front();
      checks++;
      if (r !== e.r) begin
        errors++;
        $display("FAIL fadd_%0d result got %h want %h", i, r, e.r);
      end
      checks++;
      if (f !== e.f) begin
        errors++;
        $display("FAIL fadd_%0d flags got %b want %b", i, f, e.f);
      end
      checks++;
      if (z !== e.z) begin
        errors++;
        $display("FAIL fadd_%0d zero got %b want %b", i, z, e.z);
      end
      checks++;
      if (lat != 3) begin
        errors++;
        $display("FAIL fadd_%0d latency got %0d want 3", i, lat);
      end
    end
  endtask

  task automatic test_fmul();
    logic [15:0] xa [4] = '{16'h0001, 16'h3C00, 16'h4000, 16'h0400};
    logic [15:0] xb [4] = '{16'h3800, 16'hC000, 16'h4200, 16'h3800};
    logic [15:0] er [4] = '{16'h0000, 16'hC000, 16'h4600, 16'h0200};
    logic [3:0]  ef [4] = '{4'b0011, 4'b0000, 4'b0000, 4'b0000};
    logic [31:0] r;
    logic [3:0]  f;
    logic        z;
    int          lat;
    sb_t         e;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back('{r: {16'h0, er[i]}, f: ef[i],
                       z: er[i][14:0] == 15'h0});
      send(1'b0, {16'h0, xa[i]}, {16'h0, xb[i]}, `FPU_FMUL);
      collect(1'b0, r, f, z, lat);
      e = sb_q.pop_front();
      checks++;
      if (r !== e.r) begin
        errors++;
        $display("FAIL fmul_%0d result got %h want %h", i, r, e.r);
      end
      checks++;
      if (f !== e.f) begin
        errors++;
        $display("FAIL fmul_%0d flags got %b want %b", i, f, e.f);
      end
      checks++;
      if (z !== e.z || lat != 3) begin
        errors++;
        $display("FAIL fmul_%0d zero/lat got %b/%0d want %b/3",
                 i, z, lat, e.z);
      end
    end
  endtask

  task automatic test_special();
    logic [15:0] xa [9] = '{16'h7BFF, 16'h7C00, 16'h7C01, 16'h7E00,
                            16'h0000, 16'h7C00, 16'h8000, 16'h8000,
                            16'h3C00};
    logic [15:0] xb [9] = '{16'h7BFF, 16'hFC00, 16'h3C00, 16'h3C00,
                            16'h7C00, 16'h3C00, 16'h8000, 16'h3C00,
                            16'h3C00};
    logic [3:0]  to [9] = '{`FPU_FADD, `FPU_FADD, `FPU_FADD, `FPU_FADD,
                            `FPU_FMUL, `FPU_FADD, `FPU_FADD, `FPU_FMUL,
                            4'hF};
    logic [15:0] er [9] = '{16'h7C00, 16'h7E00, 16'h7E00, 16'h7E00,
                            16'h7E00, 16'h7C00, 16'h8000, 16'h8000,
                            16'h0000};
    logic [3:0]  ef [9] = '{4'b0101, 4'b1000, 4'b1000, 4'b0000,
                            4'b1000, 4'b0000, 4'b0000, 4'b0000,
                            4'b0000};
    logic [31:0] r;
    logic [3:0]  f;
    logic        z;
    int          lat;
    sb_t         e;
    for (int i = 0; i < 9; i++) begin
      sb_q.push_back('{r: {16'h0, er[i]}, f: ef[i],
                       z: er[i][14:0] == 15'h0});
      send(1'b0, {16'h0, xa[i]}, {16'h0, xb[i]}, to[i]);
      collect(1'b0, r, f, z, lat);
      e = sb_q.pop_front();
      checks++;
      if (r !== e.r) begin
        errors++;
        $display("FAIL special_%0d result got %h want %h", i, r, e.r);
      end
      checks++;
      if (f !== e.f) begin
        errors++;
        $display("FAIL special_%0d flags got %b want %b", i, f, e.f);
      end
      checks++;
      if (z !== e.z || lat != 3) begin
        errors++;
        $display("FAIL special_%0d zero/lat got %b/%0d want %b/3",
                 i, z, lat, e.z);
      end
    end
  endtask

  task automatic test_handshake();
    sb_t e;
    int  n;
    bit  seen;
    sb_q.push_back('{r: 32'h4200, f: 4'b0000, z: 1'b0});
    send(1'b0, 32'h3C00, 32'h4000, `FPU_FADD);
    e = sb_q.pop_front();
    n = 0;
    @(negedge clk);
    while (!h_ov && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL hs_wait out_valid stuck 0, want 1");
    end
    av   = 32'h7BFF;
    bv   = 32'h7BFF;
    h_iv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (h_res !== e.r[15:0] || h_flg !== e.f) begin
        errors++;
        $display("FAIL hs_hold_%0d result got %h/%b want %h/%b",
                 i, h_res, h_flg, e.r[15:0], e.f);
      end
      checks++;
      if (h_ov !== 1'b1 || h_ir !== 1'b0) begin
        errors++;
        $display("FAIL hs_hold_%0d valid/ready got %b%b want 10",
                 i, h_ov, h_ir);
      end
    end
    h_iv = 1'b0;
    h_or = 1'b1;
    @(posedge clk);
    #1;
    h_or = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (h_ov) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || h_ir !== 1'b1) begin
      errors++;
      $display("FAIL hs_ignored extra_valid/ready got %b%b want 01",
               seen, h_ir);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    send(1'b0, 32'h3C00, 32'h3C00, `FPU_FADD);
    rst_n = 1'b0;
    #1;
    checks++;
    if (h_ov !== 1'b0 || h_ir !== 1'b0 || h_z !== 1'b1) begin
      errors++;
      $display("FAIL midrst_outputs got v%b r%b z%b want v0 r0 z1",
               h_ov, h_ir, h_z);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (h_ov) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_result out_valid got 1 want 0");
    end
    checks++;
    if (h_ir !== 1'b1 || h_res !== 16'h0) begin
      errors++;
      $display("FAIL midrst_idle ready/result got %b/%h want 1/0000",
               h_ir, h_res);
    end
  endtask

  task automatic test_sp32();
    logic [31:0] xa [3] = '{32'h3F800000, 32'h7F7FFFFF, 32'h3F800000};
    logic [31:0] xb [3] = '{32'h3F800000, 32'h40000000, 32'h3F800000};
    logic [3:0]  to [3] = '{`FPU_FADD, `FPU_FMUL, `FPU_FMUL};
    logic [31:0] er [3] = '{32'h40000000, 32'h7F800000, 32'h3F800000};
    logic [3:0]  ef [3] = '{4'b0000, 4'b0101, 4'b0000};
    logic [31:0] r;
    logic [3:0]  f;
    logic        z;
    int          lat;
    sb_t         e;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{r: er[i], f: ef[i], z: er[i][30:0] == 31'h0});
      send(1'b1, xa[i], xb[i], to[i]);
      collect(1'b1, r, f, z, lat);
      e = sb_q.pop_front();
      checks++;
      if (r !== e.r) begin
        errors++;
        $display("FAIL sp32_%0d result got %h want %h", i, r, e.r);
      end
      checks++;
      if (f !== e.f || z !== e.z || lat != 3) begin
        errors++;
        $display("FAIL sp32_%0d flags/zero/lat got %b/%b/%0d want %b/%b/3",
                 i, f, z, lat, e.f, e.z);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    av    = '0;
    bv    = '0;
    op    = '0;
    h_iv  = 1'b0;
    h_or  = 1'b0;
    s_iv  = 1'b0;
    s_or  = 1'b0;
    test_reset();
    test_fadd();
    test_fmul();
    test_special();
    test_handshake();
    test_reset_mid();
    test_sp32();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout sim time exceeded");
    $fatal(1, "timeout");
  end

endmodule
